// File: rtl/cordic_angle_sequencer_if.sv
// rtl/cordic_angle_sequencer_if.sv - run control and angle/shift beat stream between requester and sequencer
interface cordic_angle_sequencer_if #(
    parameter int WIDTH   = 17,
    parameter int SHIFT_W = 5
);
    logic               start;
    logic               mode;
    logic               abort;
    logic               out_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_angle;
    logic [SHIFT_W-1:0] out_shift;
    logic               out_last;
    logic               busy;
    logic               done;

    // Requester / CORDIC datapath side
    modport master (
        output start, mode, abort, out_ready,
        input  out_valid, out_angle, out_shift, out_last, busy, done
    );

    // Sequencer side
    modport slave (
        input  start, mode, abort, out_ready,
        output out_valid, out_angle, out_shift, out_last, busy, done
    );
endinterface

// File: rtl/cordic_angle_sequencer.sv
// rtl/cordic_angle_sequencer.sv - streams per-iteration CORDIC (angle, shift) pairs for circular or hyperbolic runs
module cordic_angle_sequencer #(
    parameter int WIDTH   = 17,
    parameter int DEPTH   = 15,
    parameter int SHIFT_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cordic_angle_sequencer_if.slave bus
);

    // Round-half-up: add half an output LSB (Q1.32 domain) before dropping 33-WIDTH bits.
    localparam int          RND_SH = (WIDTH < 33) ? (32 - WIDTH) : 0;
    localparam logic [33:0] RND    = (WIDTH < 33) ? (34'd1 << RND_SH) : 34'd0;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_state_nx;
    logic               r_mode, w_mode_nx;
    logic [SHIFT_W-1:0] r_shift, w_shift_nx;
    logic [SHIFT_W-1:0] r_beat, w_beat_nx;
    logic               r_second, w_second_nx;
    logic               r_last, w_last_nx;
    logic [WIDTH-1:0]   r_angle, w_angle_nx;
    logic               w_load;
    logic               w_xfer;
    logic               w_rep_point;

    // Q1.32 master constants indexed by shift; hyperbolic shift 0 has no entry.
    function automatic logic [32:0] f_master(input logic hyp, input logic [4:0] idx);
        logic [32:0] c;
        c = '0;
        if (!hyp) begin
            case (idx)
                5'd0:  c = 33'd3373259426;
                5'd1:  c = 33'd1991351318;
                5'd2:  c = 33'd1052175346;
                5'd3:  c = 33'd534100635;
                5'd4:  c = 33'd268086748;
                5'd5:  c = 33'd134174063;
                5'd6:  c = 33'd67103403;
                5'd7:  c = 33'd33553749;
                5'd8:  c = 33'd16777131;
                5'd9:  c = 33'd8388597;
                5'd10: c = 33'd4194303;
                5'd11: c = 33'd2097152;
                5'd12: c = 33'd1048576;
                5'd13: c = 33'd524288;
                5'd14: c = 33'd262144;
                5'd15: c = 33'd131072;
                5'd16: c = 33'd65536;
                5'd17: c = 33'd32768;
                5'd18: c = 33'd16384;
                5'd19: c = 33'd8192;
                5'd20: c = 33'd4096;
                5'd21: c = 33'd2048;
                5'd22: c = 33'd1024;
                5'd23: c = 33'd512;
                default: c = '0;
            endcase
        end else begin
            case (idx)
                5'd1:  c = 33'd2359251925;
                5'd2:  c = 33'd1096989674;
                5'd3:  c = 33'd539693625;
                5'd4:  c = 33'd268785803;
                5'd5:  c = 33'd134261444;
                5'd6:  c = 33'd67114326;
                5'd7:  c = 33'd33555115;
                5'd8:  c = 33'd16777301;
                5'd9:  c = 33'd8388619;
                5'd10: c = 33'd4194305;
                5'd11: c = 33'd2097152;
                5'd12: c = 33'd1048576;
                5'd13: c = 33'd524288;
                5'd14: c = 33'd262144;
                5'd15: c = 33'd131072;
                5'd16: c = 33'd65536;
                5'd17: c = 33'd32768;
                5'd18: c = 33'd16384;
                5'd19: c = 33'd8192;
                5'd20: c = 33'd4096;
                5'd21: c = 33'd2048;
                5'd22: c = 33'd1024;
                5'd23: c = 33'd512;
                default: c = '0;
            endcase
        end
        return c;
    endfunction

    function automatic logic [WIDTH-1:0] f_round(input logic [32:0] c);
        logic [33:0] sum;
        sum = {1'b0, c} + RND;
        return WIDTH'(sum >> (33 - WIDTH));
    endfunction

    assign w_xfer      = (r_state == S_RUN) && bus.out_ready;
    // Hyperbolic convergence needs shifts 4 and 13 issued twice.
    assign w_rep_point = r_mode && ((r_shift == SHIFT_W'(4)) || (r_shift == SHIFT_W'(13)));

    // Next-state and next-beat selection; abort overrides any same-cycle transfer.
    always_comb begin
        w_state_nx  = r_state;
        w_mode_nx   = r_mode;
        w_shift_nx  = r_shift;
        w_beat_nx   = r_beat;
        w_second_nx = r_second;
        w_last_nx   = r_last;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nx  = S_RUN;
                    w_mode_nx   = bus.mode;
                    w_shift_nx  = bus.mode ? SHIFT_W'(1) : SHIFT_W'(0);
                    w_beat_nx   = '0;
                    w_second_nx = 1'b0;
                    w_last_nx   = 1'b0;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_nx = S_IDLE;
                end else if (w_xfer) begin
                    if (r_last) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_beat_nx = r_beat + 1'b1;
                        w_last_nx = (w_beat_nx == SHIFT_W'(DEPTH - 1));
                        w_load    = 1'b1;
                        if (w_rep_point && !r_second) begin
                            w_second_nx = 1'b1;
                        end else begin
                            w_shift_nx  = r_shift + 1'b1;
                            w_second_nx = 1'b0;
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        w_angle_nx = w_load ? f_round(f_master(w_mode_nx, 5'(w_shift_nx))) : r_angle;
    end

    // State and beat registers; async reset clears every visible output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mode   <= 1'b0;
            r_shift  <= '0;
            r_beat   <= '0;
            r_second <= 1'b0;
            r_last   <= 1'b0;
            r_angle  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_mode   <= w_mode_nx;
            r_shift  <= w_shift_nx;
            r_beat   <= w_beat_nx;
            r_second <= w_second_nx;
            r_last   <= w_last_nx;
            r_angle  <= w_angle_nx;
        end
    end

    assign bus.out_valid = (r_state == S_RUN);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.out_angle = r_angle;
    assign bus.out_shift = r_shift;
    assign bus.out_last  = r_last;

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// tb/tb_cordic_angle_sequencer.sv - randomized self-checking bench for cordic_angle_sequencer
module tb_cordic_angle_sequencer;
    localparam int DEPTH = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cordic_angle_sequencer_if #(.WIDTH(17), .SHIFT_W(5)) b17 ();
    cordic_angle_sequencer_if #(.WIDTH(12), .SHIFT_W(5)) b12 ();

    cordic_angle_sequencer #(.WIDTH(17), .DEPTH(DEPTH), .SHIFT_W(5)) u_dut17 (.clk(clk), .rst_n(rst_n), .bus(b17));
    cordic_angle_sequencer #(.WIDTH(12), .DEPTH(DEPTH), .SHIFT_W(5)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(b12));

    int checks = 0;
    int errors = 0;
    bit sel12  = 1'b0;

    longint exp_s[$];
    longint exp_a[$];
    longint got_s[$];
    longint got_a[$];
    bit     got_l[$];

    // Reference: exact elementary angle rounded to Q1.32, then round-half-up to w-1 fraction bits.
    function automatic longint ref_angle(bit hyp, int s, int w);
        real x, v;
        longint c;
        x = $pow(2.0, -1.0 * s);
        v = hyp ? $atanh(x) : $atan(x);
        c = longint'($floor(v * 4294967296.0 + 0.5));
        return (c + (longint'(1) << (32 - w))) >> (33 - w);
    endfunction

    task automatic build_model(input bit hyp, input int w);
        int s;
        exp_s.delete();
        exp_a.delete();
        s = hyp ? 1 : 0;
        while (exp_s.size() < DEPTH) begin
            exp_s.push_back(s);
            exp_a.push_back(ref_angle(hyp, s, w));
            if (hyp && (s == 4 || s == 13) && exp_s.size() < DEPTH) begin
                exp_s.push_back(s);
                exp_a.push_back(ref_angle(hyp, s, w));
            end
            s++;
        end
    endtask

    function automatic int seq_mismatch();
        if (got_s.size() != DEPTH) return 100 + got_s.size();
        for (int k = 0; k < DEPTH; k++)
            if (got_s[k] != exp_s[k] || got_a[k] != exp_a[k] || got_l[k] != (k == DEPTH - 1)) return k;
        return -1;
    endfunction

    function automatic bit cur_valid(); return sel12 ? b12.out_valid : b17.out_valid; endfunction
    function automatic bit cur_done();  return sel12 ? b12.done : b17.done; endfunction
    function automatic bit cur_busy();  return sel12 ? b12.busy : b17.busy; endfunction
    function automatic bit cur_last();  return sel12 ? b12.out_last : b17.out_last; endfunction
    function automatic longint cur_shift(); return sel12 ? longint'(b12.out_shift) : longint'(b17.out_shift); endfunction
    function automatic longint cur_angle(); return sel12 ? longint'(b12.out_angle) : longint'(b17.out_angle); endfunction

    task automatic set_in(input bit st, input bit m, input bit ab, input bit rdy);
        if (sel12) begin
            b12.start = st; b12.mode = m; b12.abort = ab; b12.out_ready = rdy;
        end else begin
            b17.start = st; b17.mode = m; b17.abort = ab; b17.out_ready = rdy;
        end
    endtask

    task automatic record_beat();
        got_s.push_back(cur_shift());
        got_a.push_back(cur_angle());
        got_l.push_back(cur_last());
    endtask

    // Runs one sequence; returns the cycle (1 = first beat cycle) where done was seen.
    task automatic collect(input bit hyp, input bit rnd_ready, output int done_cyc, output bit timed_out);
        bit rdy;
        got_s.delete(); got_a.delete(); got_l.delete();
        done_cyc  = -1;
        timed_out = 1'b1;
        @(negedge clk); set_in(1'b1, hyp, 1'b0, 1'b1);
        @(negedge clk); set_in(1'b0, hyp, 1'b0, 1'b1);
        for (int cyc = 1; cyc < 1000; cyc++) begin
            if (cur_done()) begin
                done_cyc  = cyc;
                timed_out = 1'b0;
                break;
            end
            rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            set_in(1'b0, hyp, 1'b0, rdy);
            if (cur_valid() && rdy) record_beat();
            @(negedge clk);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b17.start = 0; b17.mode = 0; b17.abort = 0; b17.out_ready = 1;
        b12.start = 0; b12.mode = 0; b12.abort = 0; b12.out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({b17.out_valid, b17.busy, b17.done, b17.out_last} !== 4'b0) begin errors++; $display("FAIL reset_flags17 got %b want 0000", {b17.out_valid, b17.busy, b17.done, b17.out_last}); end
        checks++; if (b17.out_angle !== 17'd0 || b17.out_shift !== 5'd0) begin errors++; $display("FAIL reset_data17 got angle %0d shift %0d want 0 0", b17.out_angle, b17.out_shift); end
        checks++; if ({b12.out_valid, b12.busy, b12.done, b12.out_last} !== 4'b0 || b12.out_angle !== 12'd0 || b12.out_shift !== 5'd0) begin errors++; $display("FAIL reset_all12 got nonzero output"); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_circular();
        int dc; bit to;
        sel12 = 0;
        build_model(1'b0, 17);
        collect(1'b0, 1'b0, dc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL circ_timeout got timeout want done"); end
        checks++; if (got_s.size() !== DEPTH) begin errors++; $display("FAIL circ_count got %0d want %0d", got_s.size(), DEPTH); end
        for (int k = 0; k < DEPTH && k < got_s.size(); k++) begin
            checks++;
            if (got_s[k] !== exp_s[k] || got_a[k] !== exp_a[k] || got_l[k] !== (k == DEPTH - 1)) begin
                errors++;
                $display("FAIL circ_beat%0d got (%0d,%0d,%0b) want (%0d,%0d,%0b)", k, got_s[k], got_a[k], got_l[k], exp_s[k], exp_a[k], k == DEPTH - 1);
            end
        end
        checks++; if (got_a.size() < 4 || got_a[0] !== 64'd51472 || got_a[1] !== 64'd30386 || got_a[2] !== 64'd16055 || got_a[3] !== 64'd8150) begin errors++; $display("FAIL circ_first4 got unexpected angles want 51472 30386 16055 8150"); end
        checks++; if (dc !== DEPTH + 1) begin errors++; $display("FAIL circ_done_cycle got %0d want %0d", dc, DEPTH + 1); end
        @(negedge clk);
        checks++; if (cur_done() !== 1'b0 || cur_busy() !== 1'b0) begin errors++; $display("FAIL circ_after_done got done %0b busy %0b want 0 0", cur_done(), cur_busy()); end
    endtask

    task automatic test_hyperbolic();
        int dc; bit to; int m;
        sel12 = 0;
        build_model(1'b1, 17);
        collect(1'b1, 1'b0, dc, to);
        m = seq_mismatch();
        checks++; if (to !== 1'b0 || m !== -1) begin errors++; $display("FAIL hyp_sequence got mismatch code %0d timeout %0b want -1 0", m, to); end
        checks++; if (got_s.size() < 5 || got_s[3] !== 64'd4 || got_s[4] !== 64'd4 || got_a[3] !== 64'd4101 || got_a[4] !== 64'd4101) begin errors++; $display("FAIL hyp_shift4 got wrong repeat beats want two (4,4101)"); end
        checks++; if (got_s.size() != DEPTH || got_s[DEPTH-2] !== 64'd13 || got_s[DEPTH-1] !== 64'd13 || got_l[DEPTH-1] !== 1'b1) begin errors++; $display("FAIL hyp_tail got bad final beats want 13,13 with last"); end
        checks++; if (dc !== DEPTH + 1) begin errors++; $display("FAIL hyp_done_cycle got %0d want %0d", dc, DEPTH + 1); end
    endtask

    task automatic test_backpressure();
        int stall; int m; bit fin;
        sel12 = 0;
        build_model(1'b0, 17);
        got_s.delete(); got_a.delete(); got_l.delete();
        stall = 0; fin = 0;
        @(negedge clk); set_in(1, 0, 0, 1);
        @(negedge clk); set_in(0, 0, 0, 1);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cur_done()) begin fin = 1; break; end
            if (cur_valid() && got_s.size() == 2 && stall < 5) begin
                set_in(0, 0, 0, 0);
                checks++;
                if (cur_shift() !== 64'd2 || cur_angle() !== 64'd16055 || cur_last() !== 1'b0) begin
                    errors++; $display("FAIL bp_frozen%0d got (%0d,%0d,%0b) want (2,16055,0)", stall, cur_shift(), cur_angle(), cur_last());
                end
                stall++;
            end else begin
                set_in(0, 0, 0, 1);
                if (cur_valid()) record_beat();
            end
            @(negedge clk);
        end
        set_in(0, 0, 0, 1);
        m = seq_mismatch();
        checks++; if (fin !== 1'b1 || stall !== 5 || m !== -1) begin errors++; $display("FAIL bp_sequence got fin %0b stalls %0d mismatch %0d want 1 5 -1", fin, stall, m); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int n; int dc; bit to; bit seen_done;
        sel12 = 0;
        set_in(0, 0, 1, 1);
        @(negedge clk); set_in(0, 0, 0, 1);
        checks++; if (cur_busy() !== 1'b0 || cur_valid() !== 1'b0) begin errors++; $display("FAIL abort_idle got busy %0b want 0", cur_busy()); end
        @(negedge clk); set_in(1, 0, 0, 1);
        @(negedge clk); set_in(0, 0, 0, 1);
        n = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (cur_valid()) begin
                if (n == 5) break;
                n++;
            end
            @(negedge clk);
        end
        checks++; if (cur_valid() !== 1'b1 || cur_shift() !== 64'd5) begin errors++; $display("FAIL abort_at_beat6 got valid %0b shift %0d want 1 5", cur_valid(), cur_shift()); end
        set_in(0, 0, 1, 1);
        @(negedge clk); set_in(0, 0, 0, 1);
        checks++; if (cur_valid() !== 1'b0 || cur_busy() !== 1'b0 || cur_done() !== 1'b0) begin errors++; $display("FAIL abort_next got valid %0b busy %0b done %0b want 0 0 0", cur_valid(), cur_busy(), cur_done()); end
        seen_done = 0;
        repeat (3) begin @(negedge clk); if (cur_done()) seen_done = 1; end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got done pulse want none"); end
        build_model(1'b0, 17);
        collect(1'b0, 1'b0, dc, to);
        checks++; if (got_s.size() == 0 || got_s[0] !== 64'd0 || seq_mismatch() !== -1) begin errors++; $display("FAIL abort_restart got mismatch %0d want -1", seq_mismatch()); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        bit fin;
        sel12 = 0;
        build_model(1'b0, 17);
        got_s.delete(); got_a.delete(); got_l.delete();
        fin = 0;
        @(negedge clk); set_in(1, 0, 0, 1);
        @(negedge clk); set_in(0, 0, 0, 1);
        for (int cyc = 1; cyc < 200; cyc++) begin
            if (cur_done()) begin
                set_in(1, 1, 0, 1);
                fin = 1;
                break;
            end
            set_in(cyc == 4 || cyc == 9, 1, 0, 1);
            if (cur_valid()) record_beat();
            @(negedge clk);
        end
        @(negedge clk); set_in(0, 0, 0, 1);
        checks++; if (cur_busy() !== 1'b0 || cur_valid() !== 1'b0) begin errors++; $display("FAIL start_in_done got busy %0b want 0", cur_busy()); end
        checks++; if (fin !== 1'b1 || seq_mismatch() !== -1) begin errors++; $display("FAIL start_in_run got mismatch %0d fin %0b want -1 1", seq_mismatch(), fin); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int dc; bit to; bit hyp; int m;
        sel12 = 0;
        for (int r = 0; r < 6; r++) begin
            hyp = 1'($urandom_range(0, 1));
            build_model(hyp, 17);
            collect(hyp, 1'b1, dc, to);
            m = seq_mismatch();
            checks++; if (to !== 1'b0 || m !== -1) begin errors++; $display("FAIL random_run%0d mode %0b got mismatch %0d timeout %0b want -1 0", r, hyp, m, to); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset(input bit use12, input int w);
        int dc; bit to;
        sel12 = use12;
        @(negedge clk); set_in(1, 1, 0, 1);
        @(negedge clk); set_in(0, 1, 0, 1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (cur_valid() !== 1'b0 || cur_busy() !== 1'b0 || cur_done() !== 1'b0 || cur_last() !== 1'b0 || cur_angle() !== 64'd0 || cur_shift() !== 64'd0) begin
            errors++; $display("FAIL async_reset_w%0d got valid %0b busy %0b angle %0d shift %0d want all 0", w, cur_valid(), cur_busy(), cur_angle(), cur_shift());
        end
        set_in(0, 0, 0, 1);
        @(negedge clk); rst_n = 1'b1;
        build_model(1'b0, w);
        collect(1'b0, 1'b0, dc, to);
        checks++; if (to !== 1'b0 || seq_mismatch() !== -1) begin errors++; $display("FAIL post_reset_run_w%0d got mismatch %0d want -1", w, seq_mismatch()); end
        if (use12) begin
            checks++; if (got_a.size() == 0 || got_a[0] !== 64'd1608) begin errors++; $display("FAIL w12_beat1 got %0d want 1608", got_a.size() ? got_a[0] : -1); end
        end
        @(negedge clk);
        sel12 = 0;
    endtask

    initial begin
        test_reset();
        test_circular();
        test_hyperbolic();
        test_backpressure();
        test_abort();
        test_start_ignored();
        test_random();
        test_async_reset(1'b0, 17);
        test_async_reset(1'b1, 12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
